// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types: EX operand forwarding encodings and the per-stage
// destination record tracked by the hazard/forwarding controller.
package cpu_pipe_pkg;

  // Widest register address a stage record can carry; narrower addresses are zero-extended.
  localparam int PIPE_AW_MAX = 8;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_WB    = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic                   valid;
    logic [PIPE_AW_MAX-1:0] dst;
    logic                   wr;
    logic                   load;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// One source operand's hit detection against EX/MEM/WB, nearest-first
// forward select, and load-use stall request.
module fwd_match
  import cpu_pipe_pkg::*;
#(
  parameter int AW       = 4,
  parameter int LOAD_LAT = 1,
  parameter int R0_ZERO  = 1
) (
  input  stage_rec_t    ex_rec,
  input  stage_rec_t    mem_rec,
  input  stage_rec_t    wb_rec,
  input  logic [AW-1:0] src,
  input  logic          used,
  output logic [1:0]    sel,
  output logic          load_stall
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_wb_load;

  function automatic logic stage_hit(input stage_rec_t r, input logic [AW-1:0] a,
                                     input logic u);
    return r.valid && r.wr && u && (r.dst == PIPE_AW_MAX'(a))
           && !((R0_ZERO != 0) && (a == '0));
  endfunction

  assign ex_hit  = stage_hit(ex_rec, src, used);
  assign mem_hit = stage_hit(mem_rec, src, used);
  assign wb_hit  = stage_hit(wb_rec, src, used);

  // A load in WB already has its data on the write-back bypass.
  assign unused_wb_load = wb_rec.load;

  always_comb begin
    sel = FWD_RF;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  // With a two-cycle load, a load in MEM only blocks when EX does not shadow it.
  assign load_stall = (ex_hit && ex_rec.load)
                    || ((LOAD_LAT == 2) && !ex_hit && mem_hit && mem_rec.load);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Load-use stall and EX operand forwarding control for an in-order pipeline.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cycles counter output.
module hazard_forward_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int AW       = 4,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 1,
  parameter int R0_ZERO  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_src_addr,
  input  logic [NSRC-1:0]      id_src_used,
  input  logic [AW-1:0]        id_dst_addr,
  input  logic                 id_reg_write,
  input  logic                 id_is_load,
  input  logic                 flush,
  output logic                 stall,
  output logic [2*NSRC-1:0]    fwd_sel
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cycles
`endif
);

  if (LOAD_LAT != 1 && LOAD_LAT != 2) begin : g_bad_load_lat
    $error("hazard_forward_ctrl: LOAD_LAT must be 1 or 2");
  end
  if (NSRC < 1 || NSRC > 4) begin : g_bad_nsrc
    $error("hazard_forward_ctrl: NSRC must be 1..4");
  end
  if (AW < 1 || AW > PIPE_AW_MAX) begin : g_bad_aw
    $error("hazard_forward_ctrl: AW out of range");
  end

  stage_rec_t          ex_q;
  stage_rec_t          mem_q;
  stage_rec_t          wb_q;
  stage_rec_t          id_rec;
  logic [NSRC-1:0]     src_stall;
  logic [2*NSRC-1:0]   sel_next;
  logic                advance;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_src
      fwd_match #(
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT),
        .R0_ZERO  (R0_ZERO)
      ) u_match (
        .ex_rec     (ex_q),
        .mem_rec    (mem_q),
        .wb_rec     (wb_q),
        .src        (id_src_addr[gi*AW +: AW]),
        .used       (id_src_used[gi]),
        .sel        (sel_next[2*gi +: 2]),
        .load_stall (src_stall[gi])
      );
    end
  endgenerate

  // Flush wins: a squashed slot never needs to wait for its operands.
  assign stall   = id_valid && !flush && (|src_stall);
  assign advance = id_valid && !stall && !flush;

  always_comb begin
    id_rec       = STAGE_BUBBLE;
    id_rec.valid = 1'b1;
    id_rec.dst   = PIPE_AW_MAX'(id_dst_addr);
    id_rec.wr    = id_reg_write;
    id_rec.load  = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      wb_q    <= STAGE_BUBBLE;
      fwd_sel <= '0;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= advance ? id_rec : STAGE_BUBBLE;
      fwd_sel <= advance ? sel_next : '0;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule
